// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: FU result handshake and writeback lanes shared by wb_arbiter and its users
// master: FU/result side (drives fu_*, observes fu_ready and wb_*); slave: the arbiter
interface wb_arbiter_if #(
  parameter int FU_COUNT = 4,
  parameter int WB_PORTS = 3,
  parameter int PRN_BITS = 6,
  parameter int INST_ID_BITS = 6,
  parameter int DATA_BITS = 64,
  parameter int SRC_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
);
  logic [FU_COUNT-1:0] fu_valid;
  logic [FU_COUNT-1:0] fu_ready;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_inst_id;
  logic [FU_COUNT-1:0] fu_prn_valid;
  logic [FU_COUNT-1:0][PRN_BITS-1:0] fu_prn;
  logic [FU_COUNT-1:0][DATA_BITS-1:0] fu_data;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS-1:0][INST_ID_BITS-1:0] wb_inst_id;
  logic [WB_PORTS-1:0] wb_prn_valid;
  logic [WB_PORTS-1:0][PRN_BITS-1:0] wb_prn;
  logic [WB_PORTS-1:0][DATA_BITS-1:0] wb_data;
  logic [WB_PORTS-1:0][SRC_BITS-1:0] wb_fu_src;
  modport master (
    output fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data,
    input fu_ready, wb_valid, wb_inst_id, wb_prn_valid, wb_prn, wb_data, wb_fu_src
  );
  modport slave (
    input fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data,
    output fu_ready, wb_valid, wb_inst_id, wb_prn_valid, wb_prn, wb_data, wb_fu_src
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of WB_PORTS registered writeback lanes among FU_COUNT one-entry result buffers
// Ports: clk; rst (async, active-low); flush (sync, drops everything held);
//        bus (slave): fu_valid/fu_ready handshake with fu_* payload in, wb_* lanes out
module wb_arbiter #(
  parameter int FU_COUNT = 4,
  parameter int WB_PORTS = 3,
  parameter int PRN_BITS = 6,
  parameter int INST_ID_BITS = 6,
  parameter int DATA_BITS = 64
) (
  input logic clk,
  input logic rst,
  input logic flush,
  wb_arbiter_if.slave bus
);
  localparam int SB = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  logic [FU_COUNT-1:0] buf_v, buf_pv, grant, load;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] buf_id;
  logic [FU_COUNT-1:0][PRN_BITS-1:0] buf_prn;
  logic [FU_COUNT-1:0][DATA_BITS-1:0] buf_data;
  logic [SB-1:0] rr_ptr, next_ptr, idx;
  logic [WB_PORTS-1:0] lane_v;
  logic [WB_PORTS-1:0][SB-1:0] lane_src;
  int cnt;
  // Scan from rr_ptr; the k-th occupied buffer found lands on lane k, so lanes stay packed.
  always_comb begin
    grant = '0;
    lane_v = '0;
    lane_src = '0;
    next_ptr = rr_ptr;
    idx = '0;
    cnt = 0;
    for (int k = 0; k < FU_COUNT; k++) begin
      idx = SB'((int'(rr_ptr) + k) % FU_COUNT);
      if (!flush && buf_v[idx] && cnt < WB_PORTS) begin
        grant[idx] = 1'b1;
        for (int l = 0; l < WB_PORTS; l++) begin
          if (l == cnt) begin
            lane_v[l] = 1'b1;
            lane_src[l] = idx;
          end
        end
        next_ptr = SB'((int'(idx) + 1) % FU_COUNT);
        cnt = cnt + 1;
      end
    end
  end
  // A buffer being granted this cycle may be refilled on the same edge.
  assign bus.fu_ready = {FU_COUNT{rst & ~flush}} & (~buf_v | grant);
  assign load = bus.fu_valid & bus.fu_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_v <= '0;
      buf_pv <= '0;
      buf_id <= '0;
      buf_prn <= '0;
      buf_data <= '0;
      rr_ptr <= '0;
      bus.wb_valid <= '0;
      bus.wb_inst_id <= '0;
      bus.wb_prn_valid <= '0;
      bus.wb_prn <= '0;
      bus.wb_data <= '0;
      bus.wb_fu_src <= '0;
    end else begin
      rr_ptr <= flush ? '0 : next_ptr;
      for (int i = 0; i < FU_COUNT; i++) begin
        buf_v[i] <= !flush && (load[i] || (buf_v[i] && !grant[i]));
        if (load[i]) begin
          buf_id[i] <= bus.fu_inst_id[i];
          buf_pv[i] <= bus.fu_prn_valid[i];
          buf_prn[i] <= bus.fu_prn[i];
          buf_data[i] <= bus.fu_data[i];
        end
      end
      for (int l = 0; l < WB_PORTS; l++) begin
        bus.wb_valid[l] <= lane_v[l];
        bus.wb_inst_id[l] <= lane_v[l] ? buf_id[lane_src[l]] : '0;
        bus.wb_prn_valid[l] <= lane_v[l] ? buf_pv[lane_src[l]] : 1'b0;
        bus.wb_prn[l] <= lane_v[l] ? buf_prn[lane_src[l]] : '0;
        bus.wb_data[l] <= lane_v[l] ? buf_data[lane_src[l]] : '0;
        bus.wb_fu_src[l] <= lane_v[l] ? lane_src[l] : '0;
      end
    end
  end
endmodule
